// File: rtl/tdm_pkg.sv
// Shared types and slot constants for the 4-channel TDM receive path.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef logic [1:0] slot_t;

    localparam int    NUM_CH = 4;
    localparam slot_t SLOT_A = 2'd0;
    localparam slot_t SLOT_B = 2'd1;
    localparam slot_t SLOT_C = 2'd2;
    localparam slot_t SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_demux_1_4_if.sv
// Serial link inputs and parallel word outputs of the TDM demultiplexer.
interface tdm_demux_1_4_if #(
    parameter int WORD_W = 4
);
    import tdm_pkg::*;

    logic              din;
    logic              frame_sync;
    logic              en;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    logic              out_valid;
    slot_t             slot;
    logic              locked;
    logic              sync_err;

    modport master (
        output din, frame_sync, en,
        input  a, b, c, d, out_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, frame_sync, en,
        output a, b, c, d, out_valid, slot, locked, sync_err
    );

endinterface

// File: rtl/tdm_chan_shreg.sv
// Per-channel collector: shifts slot bits in at the LSB; clear with shift
// restarts the word with the incoming bit.
module tdm_chan_shreg #(
    parameter int WORD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (shift_en) begin
            q_reg <= clear ? {{(WORD_W-1){1'b0}}, bit_in} : {q_reg[WORD_W-2:0], bit_in};
        end else if (clear) begin
            q_reg <= '0;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer: frame alignment FSM, slot/frame counters and the
// registered word outputs; bit collection lives in tdm_chan_shreg.
module tdm_demux_1_4
    import tdm_pkg::*;
#(
    parameter int WORD_W = 4
) (
    input logic            clk,
    input logic            rst,
    tdm_demux_1_4_if.slave bus
);

    localparam int CNT_W = $clog2(WORD_W);

    state_t            state_reg;
    slot_t             slot_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              locked_reg;
    logic              out_valid_reg;
    logic              sync_err_reg;
    logic [WORD_W-1:0] word_reg [NUM_CH];

    logic [WORD_W-1:0] shreg_q [NUM_CH];
    logic [WORD_W-1:0] word_in [NUM_CH];
    logic [NUM_CH-1:0] shift_en;

    logic acquire, resync, lose, restart, advance, word_done;

    // frame_sync while locked at slot 0 is the normal case and simply advances
    assign acquire   = bus.en && (state_reg == HUNT) && bus.frame_sync;
    assign resync    = bus.en && (state_reg == LOCKED) && bus.frame_sync && (slot_reg != SLOT_A);
    assign lose      = bus.en && (state_reg == LOCKED) && !bus.frame_sync && (slot_reg == SLOT_A);
    assign restart   = acquire || resync;
    assign advance   = bus.en && (state_reg == LOCKED) && !resync && !lose;
    assign word_done = advance && (slot_reg == SLOT_D) && (bit_cnt_reg == CNT_W'(WORD_W - 1));

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign shift_en[gi] = restart ? (gi == 0) : (advance && (slot_reg == slot_t'(gi)));

        tdm_chan_shreg #(.WORD_W(WORD_W)) u_shreg (
            .clk      (clk),
            .rst      (rst),
            .clear    (restart),
            .shift_en (shift_en[gi]),
            .bit_in   (bus.din),
            .q        (shreg_q[gi])
        );

        // channel d's final bit arrives in the same cycle the word is captured
        if (gi == NUM_CH - 1) begin : g_last
            assign word_in[gi] = {shreg_q[gi][WORD_W-2:0], bus.din};
        end else begin : g_early
            assign word_in[gi] = shreg_q[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= HUNT;
            slot_reg      <= SLOT_A;
            bit_cnt_reg   <= '0;
            locked_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            sync_err_reg  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) word_reg[i] <= '0;
        end else begin
            out_valid_reg <= word_done;
            sync_err_reg  <= resync || lose;
            if (restart) begin
                state_reg   <= LOCKED;
                locked_reg  <= 1'b1;
                slot_reg    <= SLOT_B;
                bit_cnt_reg <= '0;
            end else if (lose) begin
                state_reg   <= HUNT;
                locked_reg  <= 1'b0;
                bit_cnt_reg <= '0;
            end else if (advance) begin
                slot_reg <= slot_reg + 2'd1;
                if (slot_reg == SLOT_D) begin
                    bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + 1'b1;
                end
            end
            if (word_done) begin
                for (int i = 0; i < NUM_CH; i++) word_reg[i] <= word_in[i];
            end
        end
    end

    assign bus.a         = word_reg[SLOT_A];
    assign bus.b         = word_reg[SLOT_B];
    assign bus.c         = word_reg[SLOT_C];
    assign bus.d         = word_reg[SLOT_D];
    assign bus.out_valid = out_valid_reg;
    assign bus.sync_err  = sync_err_reg;
    assign bus.slot      = slot_reg;
    assign bus.locked    = locked_reg;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed plus randomized bench for tdm_demux_1_4, checked against a
// frame-level model that collects slot bits into per-channel queues.
module tb_tdm_demux_1_4;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    tdm_demux_1_4_if #(.WORD_W(W)) bus ();

    tdm_demux_1_4 #(.WORD_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    bit           m_locked;
    int           m_slot;
    bit           m_bits [4][$];
    logic [W-1:0] m_words [4];
    bit           m_valid;
    bit           m_err;

    function automatic logic [W-1:0] pack(input int ch);
        logic [W-1:0] w = '0;
        for (int i = 0; i < m_bits[ch].size(); i++) w = {w[W-2:0], m_bits[ch][i]};
        return w;
    endfunction

    function automatic void drop_partial();
        for (int ch = 0; ch < 4; ch++) m_bits[ch].delete();
    endfunction

    function automatic void model_edge(input bit r, input bit e, input bit di, input bit fs);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_slot   = 0;
            drop_partial();
            for (int ch = 0; ch < 4; ch++) m_words[ch] = '0;
            return;
        end
        if (!e) return;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1;
                drop_partial();
                m_bits[0].push_back(di);
                m_slot = 1;
            end
            return;
        end
        if (fs && m_slot != 0) begin
            m_err = 1'b1;
            drop_partial();
            m_bits[0].push_back(di);
            m_slot = 1;
            return;
        end
        if (!fs && m_slot == 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
            drop_partial();
            return;
        end
        m_bits[m_slot].push_back(di);
        if (m_slot == 3 && m_bits[3].size() == W) begin
            for (int ch = 0; ch < 4; ch++) m_words[ch] = pack(ch);
            m_valid = 1'b1;
            drop_partial();
        end
        m_slot = (m_slot + 1) % 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a", 32'(bus.a), 32'(m_words[0]));
        chk("b", 32'(bus.b), 32'(m_words[1]));
        chk("c", 32'(bus.c), 32'(m_words[2]));
        chk("d", 32'(bus.d), 32'(m_words[3]));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("sync_err", 32'(bus.sync_err), 32'(m_err));
        chk("slot", 32'(bus.slot), 32'(m_slot));
        chk("locked", 32'(bus.locked), 32'(m_locked));
    endtask

    task automatic tick(input bit r, input bit e, input bit di, input bit fs);
        rst            = r;
        bus.en         = e;
        bus.din        = di;
        bus.frame_sync = fs;
        @(posedge clk);
        #1;
        model_edge(r, e, di, fs);
        check_all();
        if (bus.out_valid === 1'b1) begin
            pulses++;
            $display("word a=%b b=%b c=%b d=%b t=%0t", bus.a, bus.b, bus.c, bus.d, $time);
        end
        if (bus.sync_err === 1'b1) $display("sync_err locked=%b slot=%0d t=%0t", bus.locked, bus.slot, $time);
    endtask

    // bits[3] is channel a, bits[0] channel d
    task automatic send_frame(input logic [3:0] bits, input bit gaps);
        for (int s = 0; s < 4; s++) begin
            if (gaps) tick(1'b0, 1'b0, 1'($urandom % 2), 1'($urandom % 2));
            tick(1'b0, 1'b1, bits[3-s], s == 0);
        end
    endtask

    task automatic expect_words(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                                input logic [3:0] ec, input logic [3:0] ed);
        chk({tag, "_a"}, 32'(bus.a), 32'(ea));
        chk({tag, "_b"}, 32'(bus.b), 32'(eb));
        chk({tag, "_c"}, 32'(bus.c), 32'(ec));
        chk({tag, "_d"}, 32'(bus.d), 32'(ed));
    endtask

    initial begin
        bus.en = 1'b0;
        bus.din = 1'b0;
        bus.frame_sync = 1'b0;

        // 1: reset
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        expect_words("t1", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("t1_locked", 32'(bus.locked), 32'd0);

        // 2: aligned frames
        pulses = 0;
        for (int f = 0; f < 4; f++) send_frame((f % 2 == 0) ? 4'b1011 : 4'b0101, 1'b0);
        expect_words("t2", 4'b1010, 4'b0101, 4'b1010, 4'b1111);
        chk("t2_pulses", 32'(pulses), 32'd1);

        // 3: same stream with en gaps
        pulses = 0;
        for (int f = 0; f < 4; f++) send_frame((f % 2 == 0) ? 4'b1011 : 4'b0101, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_words("t3", 4'b1010, 4'b0101, 4'b1010, 4'b1111);
        chk("t3_pulses", 32'(pulses), 32'd1);

        // 4: early frame_sync at slot c of frame 1
        pulses = 0;
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_sync_err", 32'(bus.sync_err), 32'd1);
        chk("t4_slot", 32'(bus.slot), 32'd1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_no_early_word", 32'(pulses), 32'd0);
        for (int f = 0; f < 3; f++) send_frame(4'b0110, 1'b0);
        expect_words("t4", 4'b0000, 4'b1111, 4'b1111, 4'b0000);
        chk("t4_pulses", 32'(pulses), 32'd1);

        // 5: lost sync, then 20 cycles of noise without frame_sync
        pulses = 0;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_sync_err", 32'(bus.sync_err), 32'd1);
        chk("t5_locked", 32'(bus.locked), 32'd0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'(i % 2), 1'b0);
        expect_words("t5", 4'b0000, 4'b1111, 4'b1111, 4'b0000);
        chk("t5_pulses", 32'(pulses), 32'd0);

        // 6: reset at frame 2 slot b
        send_frame(4'(($urandom)), 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        expect_words("t6_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("t6_slot", 32'(bus.slot), 32'd0);
        pulses = 0;
        for (int f = 0; f < 4; f++) send_frame(4'b1001, 1'b0);
        expect_words("t6", 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        chk("t6_pulses", 32'(pulses), 32'd1);

        // 7: random traffic, mostly aligned with occasional sync faults
        for (int i = 0; i < 600; i++) begin
            bit e, fs;
            e  = ($urandom % 4) != 0;
            fs = (m_slot == 0);
            if (($urandom % 40) == 0) fs = ~fs;
            tick(($urandom % 300) == 0, e, 1'($urandom % 2), fs);
            assert (!(bus.out_valid === 1'b1 && bus.sync_err === 1'b1)) else begin
                errors++;
                $error("FAIL valid_and_err observed=11 expected=not both");
            end
            checks++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
